pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush arbiter for an N-stage pipeline (PREIF=0 .. WB=NSTAGE-1), parametrised successor of the 7-stage controller.
//  Arbitrates per-stage stall and redirect requests, cache/TLB/MDU freezes, and exception flushes.
//  Adds two pieces of state: an SB_DEPTH-entry cached-store line tracker (load/store-after-store hazard at MEM), and a pending-flush latch.
//  The latch keeps an exception pulse that arrives during a D-side freeze.
// PARAMETERS
//  NSTAGE      7   number of pipeline stages, index 0 = PREIF
//  MEM_IDX     4   stage index that issues D-cache requests
//  EXC_IDX     4   youngest stage flushed by an exception; stages > EXC_IDX commit
//  ADDR_W      32  address width
//  LINE_OFF_W  4   line offset bits = $clog2(line words*4); compare uses [ADDR_W-1:LINE_OFF_W]
//  SB_DEPTH    4   tracked in-flight cached stores (power of 2, >=2)
// PORTS
//  clk             in   1        clock
//  rst             in   1        synchronous reset, active high
//  flush_exc_i     in   1        exception flush request (may be a 1-cycle pulse)
//  d_freeze_i      in   1        D-TLB stall | D-cache busy
//  i_freeze_i      in   1        I-TLB stall | I-cache busy
//  mdu_busy_i      in   1        mul/div FSM busy
//  stall_req_i     in   NSTAGE   bit k: stage k must hold (data hazards)
//  redirect_i      in   NSTAGE   bit k: stage k redirects fetch (ID jump k=2, EX branch-fail k=3)
//  ld_req_i        in   1        MEM-stage load/store request valid
//  ld_cached_i     in   1        MEM-stage request is cacheable
//  ld_addr_i       in   ADDR_W   MEM-stage address
//  st_push_i       in   1        cached store leaves MEM into D-cache write path
//  st_addr_i       in   ADDR_W   address of pushed store
//  st_pop_i        in   1        D-cache retired oldest tracked store
//  wr_o            out  NSTAGE   stage register write enable
//  flush_o         out  NSTAGE   stage register clear
//  dis_wr_o        out  NSTAGE   stage loads a bubble / side-effect write disable
//  icache_flush_o  out  1        kill outstanding I-fetch
//  ireq_valid_o    out  1        I-cache request allowed
//  dreq_valid_o    out  1        D-cache request allowed
//  icache_stall_o  out  1        I-cache holds ready data
//  dcache_stall_o  out  1        D-cache holds ready data
//  flush_pend_o    out  1        pending exception flush latched
//  sb_full_o       out  1        store tracker full
//  sb_err_o        out  1        sticky: pop on empty or push on full without pop
// BEHAVIOUR
//  Reset (rst=1 at posedge): tracker emptied, flush_pend=0, sb_err=0.
//   While rst=1: wr_o=0, flush_o='1, dis_wr_o=0, all req/stall/flush outputs 0.
//  Outputs are combinational from inputs plus state. Priority, highest first:
//   P1 d_freeze: wr_o=0, dis_wr_o[MEM_IDX+1:]=1, req_valid=0, both cache_stall=1.
//      If flush_exc_i is also high, set flush_pend.
//   P2 flush (flush_exc_i|flush_pend): wr_o[0]=1, wr_o[1..EXC_IDX]=0, flush_o[1..EXC_IDX]=1.
//      Stages >EXC_IDX write. dis_wr_o[EXC_IDX]=1, icache_flush=1, req_valid=0.
//      flush_pend clears this cycle.
//   P3 i_freeze|mdu_busy: same outputs as P1; mdu_busy also sets dis_wr_o[3] (HI/LO).
//   P4 local stall: k = highest index with stall_req_i[k] | (k==MEM_IDX & conflict).
//      wr_o[0..k]=0; dis_wr_o[k+1]=1 (bubble); wr_o[k+1..]=1.
//      icache_stall=1; dreq_valid = (k<MEM_IDX); ireq_valid=0.
//   P5 redirect: k = highest index with redirect_i[k]. wr_o[0]=1, flush_o[1..k-1]=1, wr_o[k..]=1.
//      icache_flush=1, ireq_valid=0, dreq_valid=1.
//   P6 normal: wr_o='1, req_valid=1, everything else 0.
//  conflict = ld_req_i & ld_cached_i & (count==SB_DEPTH | any valid entry line-matches ld_addr_i).
//  Tracker: circular FIFO, rd/wr pointers with wrap bit, count 0..SB_DEPTH.
//   push & pop in the same cycle: legal, also when full (count unchanged).
//   A pushed entry participates in the compare from the next cycle.
//   A popped entry stops matching in the same cycle.
//   pop on empty is ignored; push on full without pop is dropped; both set sb_err.
//  Tracker and flush_pend are NOT cleared by exception flush; only rst clears them.
//  A flush_pend captured during freeze is applied in the first cycle d_freeze_i=0 (1 cycle later at the earliest).
// STRUCTURE
//  pkg pipe_ctrl_pkg: stage index localparams (PREIF..WB) and typedef ctrl_vec_t = logic [NSTAGE-1:0].
//  Sub-module store_line_tracker: FIFO + line comparators + sb_err.
//  This module holds the priority arbiter and the flush_pend flop.
// TESTING
//  T1 reset: rst=1 for 2 cycles -> wr_o=0, flush_o=7'h7F; after release with no requests -> wr_o=7'h7F.
//  T2 stall_req_i=7'b0000100 -> wr_o=7'b1111000, dis_wr_o[3]=1.
//     Add stall_req_i[4] -> wr_o=7'b1100000, dis_wr_o[5]=1.
//  T3 push store 0x8000_0014, then load at 0x8000_001C -> conflict: MEM held, dreq_valid=0.
//     Load at 0x8000_0020 -> no stall. Pop -> the 0x...1C load proceeds the same cycle.
//  T4 push 4 stores with no pop -> sb_full=1; then push+pop same cycle -> count stays 4, sb_err=0.
//     5th push alone -> dropped, sb_err=1.
//  T5 d_freeze=1 for 3 cycles with a 1-cycle flush_exc_i in cycle 1 -> flush_pend=1.
//     Cycle 4 (freeze low): flush_o[1..4]=1, wr_o[0]=1. Cycle 5: flush_pend=0.
//  T6 redirect_i[3] and redirect_i[2] together -> flush_o=7'b0000110, icache_flush=1.
//     With stall_req_i[2] also high -> stall wins, flush_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - Stage index constants for the default 7-stage pipeline (PREIF .. WB).
//   - ctrl_vec_t: one bit per stage, used for write/flush/bubble vectors.
//   - arb_sel_e: which priority level currently owns the pipeline controls.
package pipe_ctrl_pkg;

    localparam int unsigned NSTAGE = 7;

    localparam int unsigned PREIF = 0;
    localparam int unsigned IF    = 1;
    localparam int unsigned ID    = 2;
    localparam int unsigned EX    = 3;
    localparam int unsigned MEM   = 4;
    localparam int unsigned DC    = 5;
    localparam int unsigned WB    = 6;

    typedef logic [NSTAGE-1:0] ctrl_vec_t;

    typedef enum logic [2:0] {
        ARB_RESET,
        ARB_DFREEZE,
        ARB_FLUSH,
        ARB_FREEZE,
        ARB_STALL,
        ARB_REDIRECT,
        ARB_NORMAL
    } arb_sel_e;

endpackage

// File: rtl/pipe_hazard_ctrl_tracker.sv
// store_line_tracker: in-flight cached store tracker for the MEM stage.
//   Circular FIFO of SB_DEPTH line tags (read/write pointers carry a wrap bit),
//   plus line comparators against the MEM-stage load/store address.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i          cached store enters the D-cache write path
//   push_tag_i      line tag of that store
//   pop_i           D-cache retired the oldest tracked store
//   ld_check_i      MEM-stage request is valid and cacheable
//   ld_tag_i        line tag of the MEM-stage request
//   conflict_o      MEM request must wait (line match or tracker full)
//   full_o          tracker holds SB_DEPTH entries
//   err_o           sticky: pop on empty, or push on full without pop
module store_line_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W    = 28,
    parameter int unsigned SB_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [TAG_W-1:0] push_tag_i,
    input  logic             pop_i,
    input  logic             ld_check_i,
    input  logic [TAG_W-1:0] ld_tag_i,
    output logic             conflict_o,
    output logic             full_o,
    output logic             err_o
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);

    logic [TAG_W-1:0] tag_q [SB_DEPTH];
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic             hit;
    logic             err_q;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(SB_DEPTH));
    assign do_pop  = pop_i & ~empty;
    // A pop in the same cycle frees the slot, so push on full is legal then.
    assign do_push = push_i & (~full | do_pop);

    // An entry is live when its distance from the read pointer is below count.
    // The head entry being popped this cycle no longer blocks the load.
    always_comb begin : match_blk
        logic [PTR_W-1:0] off;
        hit = 1'b0;
        off = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr[PTR_W-1:0];
            if (({1'b0, off} < count) && !(do_pop && (off == '0)) &&
                (tag_q[i] == ld_tag_i)) begin
                hit = 1'b1;
            end
        end
    end

    assign conflict_o = ld_check_i & (hit | (full & ~do_pop));
    assign full_o     = full;
    assign err_o      = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if ((pop_i & empty) | (push_i & full & ~pop_i)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Tag storage carries no reset; liveness comes from the pointers.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            tag_q[wr_ptr[PTR_W-1:0]] <= push_tag_i;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush arbiter for an NSTAGE pipeline.
//   Arbitrates D-side freeze, exception flush (incl. a pending-flush latch that
//   survives a D-side freeze), I-side/MDU freeze, per-stage stalls (incl. the
//   store-after-store line hazard at MEM) and fetch redirects.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_exc_i              exception flush request (may be a 1-cycle pulse)
//   d_freeze_i, i_freeze_i   D-side / I-side TLB or cache busy
//   mdu_busy_i               mul/div unit busy
//   stall_req_i[k]           stage k must hold
//   redirect_i[k]            stage k redirects fetch
//   ld_req_i, ld_cached_i,
//   ld_addr_i                MEM-stage request, cacheable flag, address
//   st_push_i, st_addr_i     cached store enters the D-cache write path
//   st_pop_i                 D-cache retired the oldest tracked store
//   wr_o, flush_o, dis_wr_o  per-stage write enable / clear / bubble
//   icache_flush_o           kill outstanding I-fetch
//   ireq_valid_o, dreq_valid_o      cache requests allowed
//   icache_stall_o, dcache_stall_o  caches hold ready data
//   flush_pend_o             pending exception flush latched
//   sb_full_o, sb_err_o      store tracker full / sticky misuse flag
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE     = 7,
    parameter int unsigned MEM_IDX    = 4,
    parameter int unsigned EXC_IDX    = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_OFF_W = 4,
    parameter int unsigned SB_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_exc_i,
    input  logic              d_freeze_i,
    input  logic              i_freeze_i,
    input  logic              mdu_busy_i,
    input  logic [NSTAGE-1:0] stall_req_i,
    input  logic [NSTAGE-1:0] redirect_i,
    input  logic              ld_req_i,
    input  logic              ld_cached_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic              st_push_i,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic              st_pop_i,
    output logic [NSTAGE-1:0] wr_o,
    output logic [NSTAGE-1:0] flush_o,
    output logic [NSTAGE-1:0] dis_wr_o,
    output logic              icache_flush_o,
    output logic              ireq_valid_o,
    output logic              dreq_valid_o,
    output logic              icache_stall_o,
    output logic              dcache_stall_o,
    output logic              flush_pend_o,
    output logic              sb_full_o,
    output logic              sb_err_o
);

    localparam int unsigned TAG_W = ADDR_W - LINE_OFF_W;

    logic              flush_pend;
    logic              flush_pend_nxt;
    logic              conflict;
    logic              sb_full;
    logic              sb_err;
    logic [NSTAGE-1:0] stall_vec;
    int unsigned       stall_k;
    int unsigned       redir_k;
    arb_sel_e          sel;
    logic              unused_addr_lsb;

    // Only line tags are compared; offset bits within a line are don't-care.
    assign unused_addr_lsb = ^{ld_addr_i[LINE_OFF_W-1:0], st_addr_i[LINE_OFF_W-1:0]};

    store_line_tracker #(
        .TAG_W    (TAG_W),
        .SB_DEPTH (SB_DEPTH)
    ) u_tracker (
        .clk        (clk),
        .rst        (rst),
        .push_i     (st_push_i),
        .push_tag_i (st_addr_i[ADDR_W-1:LINE_OFF_W]),
        .pop_i      (st_pop_i),
        .ld_check_i (ld_req_i & ld_cached_i),
        .ld_tag_i   (ld_addr_i[ADDR_W-1:LINE_OFF_W]),
        .conflict_o (conflict),
        .full_o     (sb_full),
        .err_o      (sb_err)
    );

    always_comb begin
        stall_vec          = stall_req_i;
        stall_vec[MEM_IDX] = stall_req_i[MEM_IDX] | conflict;
    end

    // Highest requesting stage wins: everything older than it must hold too.
    always_comb begin
        stall_k = 0;
        redir_k = 0;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            if (stall_vec[i]) begin
                stall_k = i;
            end
            if (redirect_i[i]) begin
                redir_k = i;
            end
        end
    end

    always_comb begin
        if (rst) begin
            sel = ARB_RESET;
        end else if (d_freeze_i) begin
            sel = ARB_DFREEZE;
        end else if (flush_exc_i | flush_pend) begin
            sel = ARB_FLUSH;
        end else if (i_freeze_i | mdu_busy_i) begin
            sel = ARB_FREEZE;
        end else if (|stall_vec) begin
            sel = ARB_STALL;
        end else if (|redirect_i) begin
            sel = ARB_REDIRECT;
        end else begin
            sel = ARB_NORMAL;
        end
    end

    always_comb begin
        wr_o           = '0;
        flush_o        = '0;
        dis_wr_o       = '0;
        icache_flush_o = 1'b0;
        ireq_valid_o   = 1'b0;
        dreq_valid_o   = 1'b0;
        icache_stall_o = 1'b0;
        dcache_stall_o = 1'b0;
        case (sel)
            ARB_RESET: begin
                flush_o = '1;
            end
            ARB_DFREEZE, ARB_FREEZE: begin
                for (int unsigned i = 0; i < NSTAGE; i++) begin
                    dis_wr_o[i] = (i > MEM_IDX);
                end
                // HI/LO write must not retire while the MDU is still busy.
                if (sel == ARB_FREEZE && mdu_busy_i) begin
                    dis_wr_o[EX] = 1'b1;
                end
                icache_stall_o = 1'b1;
                dcache_stall_o = 1'b1;
            end
            ARB_FLUSH: begin
                for (int unsigned i = 0; i < NSTAGE; i++) begin
                    wr_o[i]    = (i == 0) || (i > EXC_IDX);
                    flush_o[i] = (i >= 1) && (i <= EXC_IDX);
                end
                dis_wr_o[EXC_IDX] = 1'b1;
                icache_flush_o    = 1'b1;
            end
            ARB_STALL: begin
                for (int unsigned i = 0; i < NSTAGE; i++) begin
                    wr_o[i]     = (i > stall_k);
                    dis_wr_o[i] = (i == stall_k + 1);
                end
                icache_stall_o = 1'b1;
                dreq_valid_o   = (stall_k < MEM_IDX);
            end
            ARB_REDIRECT: begin
                for (int unsigned i = 0; i < NSTAGE; i++) begin
                    flush_o[i] = (i >= 1) && (i < redir_k);
                    wr_o[i]    = (i == 0) || (i >= redir_k);
                end
                icache_flush_o = 1'b1;
                dreq_valid_o   = 1'b1;
            end
            ARB_NORMAL: begin
                wr_o         = '1;
                ireq_valid_o = 1'b1;
                dreq_valid_o = 1'b1;
            end
            default: begin
                flush_o = '1;
            end
        endcase
    end

    // Any unfrozen cycle either applies the flush (P2) or had none pending,
    // so the latch only survives while the D side stays frozen.
    assign flush_pend_nxt = d_freeze_i ? (flush_pend | flush_exc_i) : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            flush_pend <= 1'b0;
        end else begin
            flush_pend <= flush_pend_nxt;
        end
    end

    assign flush_pend_o = flush_pend;
    assign sb_full_o    = sb_full;
    assign sb_err_o     = sb_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush_exc_i, d_freeze_i, i_freeze_i, mdu_busy_i;
    logic [6:0]  stall_req_i, redirect_i;
    logic        ld_req_i, ld_cached_i, st_push_i, st_pop_i;
    logic [31:0] ld_addr_i, st_addr_i;
    logic [6:0]  wr_o, flush_o, dis_wr_o;
    logic        icache_flush_o, ireq_valid_o, dreq_valid_o, icache_stall_o, dcache_stall_o;
    logic        flush_pend_o, sb_full_o, sb_err_o;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .NSTAGE(7), .MEM_IDX(4), .EXC_IDX(4), .ADDR_W(32), .LINE_OFF_W(4), .SB_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .flush_exc_i(flush_exc_i), .d_freeze_i(d_freeze_i),
        .i_freeze_i(i_freeze_i), .mdu_busy_i(mdu_busy_i), .stall_req_i(stall_req_i),
        .redirect_i(redirect_i), .ld_req_i(ld_req_i), .ld_cached_i(ld_cached_i),
        .ld_addr_i(ld_addr_i), .st_push_i(st_push_i), .st_addr_i(st_addr_i),
        .st_pop_i(st_pop_i), .wr_o(wr_o), .flush_o(flush_o), .dis_wr_o(dis_wr_o),
        .icache_flush_o(icache_flush_o), .ireq_valid_o(ireq_valid_o),
        .dreq_valid_o(dreq_valid_o), .icache_stall_o(icache_stall_o),
        .dcache_stall_o(dcache_stall_o), .flush_pend_o(flush_pend_o),
        .sb_full_o(sb_full_o), .sb_err_o(sb_err_o)
    );

    typedef struct packed {
        logic        rst, exc, dfz, ifz, mdu;
        logic [6:0]  stall, redir;
        logic        ld_req, ld_cached;
        logic [31:0] ld_addr;
        logic        push;
        logic [31:0] st_addr;
        logic        pop;
    } in_t;

    typedef struct packed {
        logic [6:0] wr, fl, dis;
        logic       ifl, ireq, dreq, ist, dst, pend, full, err;
    } out_t;

    typedef struct packed {
        logic [6:0] stall, redir, wr, fl, dis;
        logic       ifl;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: list of line tags in store order, pending flush, error.
    logic [27:0] sbq[$];
    bit          m_pend;
    bit          m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    function automatic out_t model_out(input in_t x);
        out_t       o;
        bit         hit;
        bit         conflict;
        logic [6:0] st;
        int         k;
        int         first;
        o      = '0;
        o.pend = m_pend;
        o.full = (sbq.size() == 4);
        o.err  = m_err;
        if (x.rst) begin
            o.fl = 7'h7F;
            return o;
        end
        hit   = 0;
        first = (x.pop && sbq.size() > 0) ? 1 : 0;
        for (int j = first; j < sbq.size(); j++)
            if (sbq[j] == x.ld_addr[31:4]) hit = 1;
        conflict = x.ld_req && x.ld_cached && ((sbq.size() == 4 && !x.pop) || hit);
        st = x.stall | (conflict ? 7'b0010000 : 7'b0);
        if (x.dfz) begin
            o.dis = 7'b1100000; o.ist = 1; o.dst = 1;
        end else if (x.exc || m_pend) begin
            o.wr = 7'b1100001; o.fl = 7'b0011110; o.dis = 7'b0010000; o.ifl = 1;
        end else if (x.ifz || x.mdu) begin
            o.dis = 7'b1100000 | (x.mdu ? 7'b0001000 : 7'b0); o.ist = 1; o.dst = 1;
        end else if (st != 0) begin
            k = 0;
            for (int j = 0; j < 7; j++) if (st[j]) k = j;
            o.wr   = 7'((32'h7F << (k + 1)) & 32'h7F);
            o.dis  = 7'((32'h1 << (k + 1)) & 32'h7F);
            o.ist  = 1;
            o.dreq = (k < 4);
        end else if (x.redir != 0) begin
            k = 0;
            for (int j = 0; j < 7; j++) if (x.redir[j]) k = j;
            o.fl   = 7'(((32'h1 << k) - 1) & 32'h7E);
            o.wr   = ~o.fl;
            o.ifl  = 1;
            o.dreq = 1;
        end else begin
            o.wr = 7'h7F; o.ireq = 1; o.dreq = 1;
        end
        return o;
    endfunction

    task automatic model_commit(input in_t x);
        bit full0, empty0;
        if (x.rst) begin
            sbq.delete(); m_pend = 0; m_err = 0;
            return;
        end
        m_pend = x.dfz ? (m_pend | x.exc) : 1'b0;
        full0  = (sbq.size() == 4);
        empty0 = (sbq.size() == 0);
        if ((x.pop && empty0) || (x.push && full0 && !x.pop)) m_err = 1;
        if (x.pop && !empty0) void'(sbq.pop_front());
        if (x.push && (!full0 || x.pop)) sbq.push_back(x.st_addr[31:4]);
    endtask

    function automatic out_t sample();
        out_t s;
        s = {wr_o, flush_o, dis_wr_o, icache_flush_o, ireq_valid_o, dreq_valid_o,
             icache_stall_o, dcache_stall_o, flush_pend_o, sb_full_o, sb_err_o};
        return s;
    endfunction

    task automatic drive(input in_t x);
        rst = x.rst; flush_exc_i = x.exc; d_freeze_i = x.dfz; i_freeze_i = x.ifz;
        mdu_busy_i = x.mdu; stall_req_i = x.stall; redirect_i = x.redir;
        ld_req_i = x.ld_req; ld_cached_i = x.ld_cached; ld_addr_i = x.ld_addr;
        st_push_i = x.push; st_addr_i = x.st_addr; st_pop_i = x.pop;
    endtask

    // Drive, let combinational outputs settle, compare against the model.
    task automatic apply(input in_t x, input string name);
        drive(x);
        #1;
        chk(name, 64'(sample()), 64'(model_out(x)));
    endtask

    task automatic tick(input in_t x);
        @(posedge clk);
        model_commit(x);
        @(negedge clk);
    endtask

    task automatic step(input in_t x, input string name);
        apply(x, name);
        tick(x);
    endtask

    vec_t tbl[8];
    in_t  v;

    initial begin
        tbl[0] = '{7'b0000100, 7'b0000000, 7'b1111000, 7'b0000000, 7'b0001000, 1'b0};
        tbl[1] = '{7'b0010100, 7'b0000000, 7'b1100000, 7'b0000000, 7'b0100000, 1'b0};
        tbl[2] = '{7'b0000000, 7'b0001100, 7'b1111001, 7'b0000110, 7'b0000000, 1'b1};
        tbl[3] = '{7'b0000100, 7'b0001100, 7'b1111000, 7'b0000000, 7'b0001000, 1'b0};
        tbl[4] = '{7'b1000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0};
        tbl[5] = '{7'b0000000, 7'b0000001, 7'b1111111, 7'b0000000, 7'b0000000, 1'b1};
        tbl[6] = '{7'b0000000, 7'b1000000, 7'b1000001, 7'b0111110, 7'b0000000, 1'b1};
        tbl[7] = '{7'b0000000, 7'b0000000, 7'b1111111, 7'b0000000, 7'b0000000, 1'b0};

        // T1 reset
        v = idle(); v.rst = 1;
        drive(v);
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_wr", 64'(wr_o), 64'h00);
        chk("rst_flush", 64'(flush_o), 64'h7F);
        chk("rst_misc", 64'({dis_wr_o, icache_flush_o, ireq_valid_o, dreq_valid_o,
                             icache_stall_o, dcache_stall_o, flush_pend_o, sb_full_o, sb_err_o}), 64'h0);
        model_commit(v);
        @(negedge clk);
        v = idle();
        apply(v, "post_rst");
        chk("post_rst_wr", 64'(wr_o), 64'h7F);
        tick(v);

        // Table-driven stall/redirect vectors (T2, T6 and stage boundaries)
        for (int i = 0; i < 8; i++) begin
            v = idle(); v.stall = tbl[i].stall; v.redir = tbl[i].redir;
            apply(v, $sformatf("tbl%0d_model", i));
            chk($sformatf("tbl%0d_wr", i), 64'(wr_o), 64'(tbl[i].wr));
            chk($sformatf("tbl%0d_flush", i), 64'(flush_o), 64'(tbl[i].fl));
            chk($sformatf("tbl%0d_dis", i), 64'(dis_wr_o), 64'(tbl[i].dis));
            chk($sformatf("tbl%0d_iflush", i), 64'(icache_flush_o), 64'(tbl[i].ifl));
            tick(v);
        end

        v = idle(); v.mdu = 1;
        apply(v, "mdu_model");
        chk("mdu_dis", 64'(dis_wr_o), 64'b1101000);
        tick(v);

        // T3 store/load line hazard
        v = idle(); v.push = 1; v.st_addr = 32'h8000_0014;
        v.ld_req = 1; v.ld_cached = 1; v.ld_addr = 32'h8000_001C;
        apply(v, "t3_push_same_cycle");
        chk("t3_push_nohaz", 64'(wr_o), 64'h7F);
        tick(v);
        v = idle(); v.ld_req = 1; v.ld_cached = 1; v.ld_addr = 32'h8000_001C;
        apply(v, "t3_conflict");
        chk("t3_conflict_wr", 64'(wr_o), 64'b1100000);
        chk("t3_conflict_dreq", 64'(dreq_valid_o), 64'h0);
        tick(v);
        v.ld_cached = 0;
        apply(v, "t3_uncached");
        chk("t3_uncached_wr", 64'(wr_o), 64'h7F);
        tick(v);
        v.ld_cached = 1; v.ld_addr = 32'h8000_0020;
        apply(v, "t3_other_line");
        chk("t3_other_line_wr", 64'(wr_o), 64'h7F);
        tick(v);
        v.ld_addr = 32'h8000_001C; v.pop = 1;
        apply(v, "t3_pop");
        chk("t3_pop_wr", 64'(wr_o), 64'h7F);
        tick(v);

        // T4 full tracker
        for (int i = 1; i <= 4; i++) begin
            v = idle(); v.push = 1; v.st_addr = 32'(i * 32'h100);
            step(v, $sformatf("t4_push%0d", i));
        end
        v = idle(); v.ld_req = 1; v.ld_cached = 1; v.ld_addr = 32'h0000_0900;
        apply(v, "t4_full_load");
        chk("t4_full", 64'(sb_full_o), 64'h1);
        chk("t4_full_conflict_wr", 64'(wr_o), 64'b1100000);
        tick(v);
        v = idle(); v.push = 1; v.pop = 1; v.st_addr = 32'h500;
        v.ld_req = 1; v.ld_cached = 1; v.ld_addr = 32'h104;
        apply(v, "t4_pushpop");
        chk("t4_pushpop_head_released", 64'(wr_o), 64'h7F);
        tick(v);
        v = idle(); v.push = 1; v.st_addr = 32'h600;
        apply(v, "t4_overflow");
        chk("t4_still_full", 64'(sb_full_o), 64'h1);
        chk("t4_no_err", 64'(sb_err_o), 64'h0);
        tick(v);
        v = idle();
        apply(v, "t4_after_drop");
        chk("t4_err", 64'(sb_err_o), 64'h1);
        tick(v);
        for (int i = 0; i < 5; i++) begin
            v = idle(); v.pop = 1;
            step(v, $sformatf("t4_pop%0d", i));
        end
        v = idle(); v.rst = 1;
        step(v, "t4_rst");

        // T5 exception pulse during D-side freeze
        v = idle(); v.dfz = 1; v.exc = 1;
        apply(v, "t5_c1");
        chk("t5_c1_pend", 64'(flush_pend_o), 64'h0);
        chk("t5_c1_wr", 64'(wr_o), 64'h0);
        tick(v);
        v = idle(); v.dfz = 1;
        apply(v, "t5_c2");
        chk("t5_c2_pend", 64'(flush_pend_o), 64'h1);
        tick(v);
        step(v, "t5_c3");
        v = idle();
        apply(v, "t5_c4");
        chk("t5_c4_flush", 64'(flush_o), 64'b0011110);
        chk("t5_c4_wr", 64'(wr_o), 64'b1100001);
        tick(v);
        apply(v, "t5_c5");
        chk("t5_c5_pend", 64'(flush_pend_o), 64'h0);
        chk("t5_c5_wr", 64'(wr_o), 64'h7F);
        tick(v);

        // Randomized traffic against the reference model
        for (int c = 0; c < 1500; c++) begin
            v = idle();
            v.rst       = ($urandom_range(0, 99) == 0);
            v.exc       = ($urandom_range(0, 11) == 0);
            v.dfz       = ($urandom_range(0, 5) == 0);
            v.ifz       = ($urandom_range(0, 9) == 0);
            v.mdu       = ($urandom_range(0, 9) == 0);
            v.stall     = 7'($urandom) & 7'($urandom) & 7'($urandom);
            v.redir     = 7'($urandom) & 7'($urandom) & 7'($urandom);
            v.ld_req    = $urandom_range(0, 1) == 1;
            v.ld_cached = $urandom_range(0, 3) != 0;
            v.ld_addr   = 32'h8000_0000 + 32'($urandom_range(0, 5) * 16) + 32'($urandom_range(0, 15));
            v.push      = $urandom_range(0, 2) == 0;
            v.st_addr   = 32'h8000_0000 + 32'($urandom_range(0, 5) * 16) + 32'($urandom_range(0, 15));
            v.pop       = $urandom_range(0, 2) == 0;
            step(v, $sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
